// File: rtl/axi_stream_mon_pkg.sv
// Shared definitions for the AXI4-Stream protocol monitor: error bit map,
// packet FSM encoding and a byte-qualifier popcount helper.
package axi_stream_mon_pkg;

   localparam int unsigned ERR_COUNT         = 7;
   localparam int unsigned ERR_VALID_DROP    = 0;
   localparam int unsigned ERR_UNSTABLE      = 1;
   localparam int unsigned ERR_RESET_VALID   = 2;
   localparam int unsigned ERR_STRB_KEEP     = 3;
   localparam int unsigned ERR_PKT_TOO_LONG  = 4;
   localparam int unsigned ERR_ROUTE_CHANGE  = 5;
   localparam int unsigned ERR_STALL_TIMEOUT = 6;

   localparam int unsigned POP_IN_W  = 256;
   localparam int unsigned POP_OUT_W = 16;

   typedef enum logic [0:0] {
      PKT_IDLE = 1'b0,
      PKT_IN   = 1'b1
   } pkt_state_e;

   // Number of set bits; callers zero-extend their qualifier vector to POP_IN_W.
   function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
      logic [POP_OUT_W-1:0] n;
      n = '0;
      for (int i = 0; i < POP_IN_W; i++) begin
         n = n + POP_OUT_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/axi_stream_packet_tracker.sv
// Packet framing tracker: open/closed state, beats in the open packet and the
// route latched on its first beat; flags over-long packets and route changes.
module axi_stream_packet_tracker
   import axi_stream_mon_pkg::*;
#(
   parameter int unsigned ROUTE_W          = 1,
   parameter int unsigned MAX_PACKET_BEATS = 256,
   parameter bit          NO_INTERLEAVE    = 1'b1
) (
   input  logic               clk_i,
   input  logic               resetn_i,
   input  logic               beat_i,
   input  logic               tlast_i,
   input  logic [ROUTE_W-1:0] route_i,
   output logic               in_packet_o,
   output logic               too_long_c_o,
   output logic               route_chg_c_o
);

   localparam int unsigned        BEATS_W   = 16;
   localparam logic [BEATS_W-1:0] MAX_BEATS = BEATS_W'(MAX_PACKET_BEATS);

   pkt_state_e         state_q, state_d;
   logic [BEATS_W-1:0] beats_q, beats_d;
   logic [ROUTE_W-1:0] route_q, route_d;

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q <= PKT_IDLE;
         beats_q <= '0;
         route_q <= '0;
      end else begin
         state_q <= state_d;
         beats_q <= beats_d;
         route_q <= route_d;
      end
   end

   // beats_q is zero whenever no packet is open, so the length check needs no state term.
   always_comb begin
      state_d       = state_q;
      beats_d       = beats_q;
      route_d       = route_q;
      too_long_c_o  = 1'b0;
      route_chg_c_o = 1'b0;
      if (beat_i) begin
         too_long_c_o  = (beats_q == MAX_BEATS);
         route_chg_c_o = NO_INTERLEAVE && (state_q == PKT_IN) && (route_i != route_q);
         if (tlast_i) begin
            state_d = PKT_IDLE;
            beats_d = '0;
         end else begin
            state_d = PKT_IN;
            if (state_q == PKT_IDLE) begin
               beats_d = BEATS_W'(1);
               route_d = route_i;
            end else if (beats_q != MAX_BEATS) begin
               beats_d = beats_q + BEATS_W'(1);
            end
         end
      end
   end

   assign in_packet_o = (state_q == PKT_IN);

endmodule

// File: rtl/axi_stream_protocol_monitor.sv
// Passive AXI4-Stream link checker: handshake, stability, reset, TKEEP/TSTRB,
// framing and stall rules, sticky error flags and saturating traffic counters.
module axi_stream_protocol_monitor
   import axi_stream_mon_pkg::*;
#(
   parameter int unsigned BYTE_WIDTH       = 4,
   parameter int unsigned KEEP_WIDTH       = 0,
   parameter int unsigned ID_WIDTH         = 0,
   parameter int unsigned DEST_WIDTH       = 0,
   parameter int unsigned USER_WIDTH       = 0,
   parameter int unsigned ASSERT_MASTER    = 1,
   parameter int unsigned NO_INTERLEAVE    = 1,
   parameter int unsigned MAX_PACKET_BEATS = 256,
   parameter int unsigned MAX_STALL        = 16,
   parameter int unsigned CNT_WIDTH        = 32,
   parameter bit          CHECK_PROPS      = 1'b1
) (
   input  logic                                               clk,
   input  logic                                               resetn,
   input  logic                                               tvalid,
   input  logic                                               tready,
   input  logic [((BYTE_WIDTH > 0) ? 8*BYTE_WIDTH : 1)-1:0]   tdata,
   input  logic [((BYTE_WIDTH > 0) ? BYTE_WIDTH : 1)-1:0]     tstrb,
   input  logic [((BYTE_WIDTH > 0) ? BYTE_WIDTH :
                  ((KEEP_WIDTH > 0) ? KEEP_WIDTH : 1))-1:0]   tkeep,
   input  logic                                               tlast,
   input  logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0]         tid,
   input  logic [((DEST_WIDTH > 0) ? DEST_WIDTH : 1)-1:0]     tdest,
   input  logic [((USER_WIDTH > 0) ? USER_WIDTH : 1)-1:0]     tuser,
   output logic [ERR_COUNT-1:0]                               err,
   output logic                                               in_packet,
   output logic [CNT_WIDTH-1:0]                               beat_count,
   output logic [CNT_WIDTH-1:0]                               packet_count,
   output logic [CNT_WIDTH-1:0]                               byte_count
);

   localparam int unsigned DATA_W  = (BYTE_WIDTH > 0) ? 8*BYTE_WIDTH : 1;
   localparam int unsigned STRB_W  = (BYTE_WIDTH > 0) ? BYTE_WIDTH : 1;
   localparam int unsigned KEEP_N  = (BYTE_WIDTH > 0) ? BYTE_WIDTH : KEEP_WIDTH;
   localparam int unsigned KEEP_W  = (KEEP_N > 0) ? KEEP_N : 1;
   localparam int unsigned ID_W    = (ID_WIDTH > 0) ? ID_WIDTH : 1;
   localparam int unsigned DEST_W  = (DEST_WIDTH > 0) ? DEST_WIDTH : 1;
   localparam int unsigned USER_W  = (USER_WIDTH > 0) ? USER_WIDTH : 1;
   localparam int unsigned ROUTE_W = ID_W + DEST_W;
   localparam int unsigned WIDE_W  = CNT_WIDTH + POP_OUT_W;
   localparam int unsigned STALL_W = $clog2(MAX_STALL + 2);

   localparam logic [STALL_W-1:0]   STALL_SAT = STALL_W'(MAX_STALL + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   logic                 resetn_q, valid_q, ready_q, last_q;
   logic [DATA_W-1:0]    data_q;
   logic [STRB_W-1:0]    strb_q;
   logic [KEEP_W-1:0]    keep_q;
   logic [ID_W-1:0]      id_q, tid_m;
   logic [DEST_W-1:0]    dest_q, tdest_m;
   logic [USER_W-1:0]    user_q;
   logic [STALL_W-1:0]   stall_q, stall_d;
   logic [ERR_COUNT-1:0] err_q, err_d, viol_c;
   logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d, pkt_cnt_q, pkt_cnt_d, byte_cnt_q, byte_cnt_d;
   logic [POP_OUT_W-1:0] keep_pop_c;
   logic [WIDE_W-1:0]    headroom_c;
   logic                 beat_c, stall_c, payload_chg_c, too_long_c, route_chg_c;

   assign beat_c     = resetn && tvalid && tready;
   assign stall_c    = resetn && tvalid && !tready;
   assign tid_m      = (ID_WIDTH > 0) ? tid : '0;
   assign tdest_m    = (DEST_WIDTH > 0) ? tdest : '0;
   assign keep_pop_c = (KEEP_N > 0) ? popcount(POP_IN_W'(tkeep)) : '0;

   // Absent signals never count as a change.
   assign payload_chg_c = (tlast != last_q)
      || ((BYTE_WIDTH > 0) && ((tdata != data_q) || (tstrb != strb_q)))
      || ((KEEP_N > 0) && (tkeep != keep_q))
      || ((ID_WIDTH > 0) && (tid != id_q))
      || ((DEST_WIDTH > 0) && (tdest != dest_q))
      || ((USER_WIDTH > 0) && (tuser != user_q));

   axi_stream_packet_tracker #(
      .ROUTE_W          (ROUTE_W),
      .MAX_PACKET_BEATS (MAX_PACKET_BEATS),
      .NO_INTERLEAVE    (NO_INTERLEAVE != 0)
   ) u_tracker (
      .clk_i         (clk),
      .resetn_i      (resetn),
      .beat_i        (beat_c),
      .tlast_i       (tlast),
      .route_i       ({tid_m, tdest_m}),
      .in_packet_o   (in_packet),
      .too_long_c_o  (too_long_c),
      .route_chg_c_o (route_chg_c)
   );

   always_comb begin
      stall_d    = '0;
      viol_c     = '0;
      beat_cnt_d = beat_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
      byte_cnt_d = byte_cnt_q;
      headroom_c = WIDE_W'(CNT_MAX) - WIDE_W'(byte_cnt_q);
      if (stall_c) begin
         stall_d = (stall_q == STALL_SAT) ? STALL_SAT : stall_q + STALL_W'(1);
      end
      viol_c[ERR_VALID_DROP]    = resetn && resetn_q && valid_q && !ready_q && !tvalid;
      viol_c[ERR_UNSTABLE]      = resetn && resetn_q && valid_q && !ready_q && payload_chg_c;
      viol_c[ERR_RESET_VALID]   = resetn && !resetn_q && tvalid;
      viol_c[ERR_STRB_KEEP]     = resetn && tvalid && (BYTE_WIDTH > 0)
                                  && (|(KEEP_W'(tstrb) & ~tkeep));
      viol_c[ERR_PKT_TOO_LONG]  = too_long_c;
      viol_c[ERR_ROUTE_CHANGE]  = route_chg_c;
      viol_c[ERR_STALL_TIMEOUT] = (stall_d > STALL_W'(MAX_STALL));
      err_d = err_q | viol_c;
      if (beat_c) begin
         if (beat_cnt_q != CNT_MAX) beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
         if (tlast && (pkt_cnt_q != CNT_MAX)) pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
         byte_cnt_d = (WIDE_W'(keep_pop_c) > headroom_c) ? CNT_MAX
                                                         : byte_cnt_q + CNT_WIDTH'(keep_pop_c);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         resetn_q   <= 1'b0;
         valid_q    <= 1'b0;
         ready_q    <= 1'b0;
         last_q     <= 1'b0;
         data_q     <= '0;
         strb_q     <= '0;
         keep_q     <= '0;
         id_q       <= '0;
         dest_q     <= '0;
         user_q     <= '0;
         stall_q    <= '0;
         err_q      <= '0;
         beat_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         byte_cnt_q <= '0;
      end else begin
         resetn_q   <= 1'b1;
         valid_q    <= tvalid;
         ready_q    <= tready;
         last_q     <= tlast;
         data_q     <= tdata;
         strb_q     <= tstrb;
         keep_q     <= tkeep;
         id_q       <= tid;
         dest_q     <= tdest;
         user_q     <= tuser;
         stall_q    <= stall_d;
         err_q      <= err_d;
         beat_cnt_q <= beat_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   assign err          = err_q;
   assign beat_count   = beat_cnt_q;
   assign packet_count = pkt_cnt_q;
   assign byte_count   = byte_cnt_q;

   // Master rules (bits 0-5) and the slave stall rule swap assert/assume roles.
   if (CHECK_PROPS) begin : g_props
      for (genvar i = 0; i < ERR_COUNT; i++) begin : g_rule
         if ((i != ERR_STALL_TIMEOUT) == (ASSERT_MASTER != 0)) begin : g_assert
            a_rule: assert property (@(posedge clk) !viol_c[i]);
         end else begin : g_assume
            m_rule: assume property (@(posedge clk) !viol_c[i]);
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_protocol_monitor.sv
// Directed scoreboard bench for axi_stream_protocol_monitor: three monitors share one
// stimulated link (interleave on/off, 32-bit and 3-bit counters).
module tb_axi_stream_protocol_monitor;

   logic        clk = 1'b0;
   logic        resetn, tvalid, tready, tlast;
   logic [31:0] tdata;
   logic [3:0]  tstrb, tkeep;
   logic [1:0]  tid;
   logic        tdest, tuser;

   logic [6:0]  err_a, err_b, err_c;
   logic        inp_a, inp_b, inp_c;
   logic [31:0] beats_a, pkts_a, bytes_a, beats_b, pkts_b, bytes_b;
   logic [2:0]  beats_c, pkts_c, bytes_c;

   typedef struct {
      logic [6:0]  err_a;
      logic [6:0]  err_b;
      logic        inp;
      logic [31:0] beats;
      logic [31:0] pkts;
      logic [31:0] bytes;
   } exp_t;

   exp_t        exp_q[$];
   string       name_q[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   axi_stream_protocol_monitor #(
      .BYTE_WIDTH(4), .ID_WIDTH(2), .MAX_PACKET_BEATS(4), .MAX_STALL(16),
      .NO_INTERLEAVE(1), .CNT_WIDTH(32), .CHECK_PROPS(1'b0)
   ) u_dut_a (
      .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready), .tdata(tdata),
      .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser),
      .err(err_a), .in_packet(inp_a), .beat_count(beats_a), .packet_count(pkts_a),
      .byte_count(bytes_a)
   );

   axi_stream_protocol_monitor #(
      .BYTE_WIDTH(4), .ID_WIDTH(2), .MAX_PACKET_BEATS(4), .MAX_STALL(16),
      .NO_INTERLEAVE(0), .CNT_WIDTH(32), .CHECK_PROPS(1'b0)
   ) u_dut_b (
      .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready), .tdata(tdata),
      .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser),
      .err(err_b), .in_packet(inp_b), .beat_count(beats_b), .packet_count(pkts_b),
      .byte_count(bytes_b)
   );

   axi_stream_protocol_monitor #(
      .BYTE_WIDTH(4), .ID_WIDTH(2), .MAX_PACKET_BEATS(4), .MAX_STALL(16),
      .NO_INTERLEAVE(1), .CNT_WIDTH(3), .CHECK_PROPS(1'b0)
   ) u_dut_c (
      .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready), .tdata(tdata),
      .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser),
      .err(err_c), .in_packet(inp_c), .beat_count(beats_c), .packet_count(pkts_c),
      .byte_count(bytes_c)
   );

   function automatic logic [31:0] sat3(input logic [31:0] v);
      return (v > 32'd7) ? 32'd7 : v;
   endfunction

   task automatic cmp(input string nm, input string field, input logic [31:0] act,
                      input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h, required %0h", nm, field, act, req);
      end
   endtask

   // Checker: pops one expectation per cycle, mid-cycle, while outputs are stable.
   initial begin : monitor
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            cmp(nm, "err_a",   32'(err_a),   32'(e.err_a));
            cmp(nm, "err_b",   32'(err_b),   32'(e.err_b));
            cmp(nm, "err_c",   32'(err_c),   32'(e.err_a));
            cmp(nm, "inp_a",   32'(inp_a),   32'(e.inp));
            cmp(nm, "inp_b",   32'(inp_b),   32'(e.inp));
            cmp(nm, "inp_c",   32'(inp_c),   32'(e.inp));
            cmp(nm, "beats_a", beats_a,      e.beats);
            cmp(nm, "beats_b", beats_b,      e.beats);
            cmp(nm, "beats_c", 32'(beats_c), sat3(e.beats));
            cmp(nm, "pkts_a",  pkts_a,       e.pkts);
            cmp(nm, "pkts_b",  pkts_b,       e.pkts);
            cmp(nm, "pkts_c",  32'(pkts_c),  sat3(e.pkts));
            cmp(nm, "bytes_a", bytes_a,      e.bytes);
            cmp(nm, "bytes_b", bytes_b,      e.bytes);
            cmp(nm, "bytes_c", 32'(bytes_c), sat3(e.bytes));
         end
      end
   end

   task automatic push_exp(input string nm, input logic [6:0] ea, input logic [6:0] eb,
                           input logic ip, input int unsigned bt, input int unsigned pk,
                           input int unsigned by);
      exp_t e;
      e.err_a = ea;
      e.err_b = eb;
      e.inp   = ip;
      e.beats = bt;
      e.pkts  = pk;
      e.bytes = by;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic step(input logic v, input logic r, input logic l, input logic [31:0] d,
                       input logic [3:0] k, input logic [3:0] s, input logic [1:0] id);
      tvalid = v;
      tready = r;
      tlast  = l;
      tdata  = d;
      tkeep  = k;
      tstrb  = s;
      tid    = id;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic l, input logic [31:0] d, input logic [1:0] id);
      step(1'b1, 1'b1, l, d, 4'hF, 4'hF, id);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 4'hF, 2'd0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      idle();
      resetn = 1'b1;
      idle();
   endtask

   initial begin : stimulus
      resetn = 1'b0;
      tdest  = 1'b0;
      tuser  = 1'b0;
      idle();
      idle();
      push_exp("reset", 7'h00, 7'h00, 1'b0, 0, 0, 0);
      resetn = 1'b1;
      idle();

      // Packets of 4, 1 and 2 beats.
      beat(1'b0, 32'h1111_0001, 2'd0);
      beat(1'b0, 32'h1111_0002, 2'd0);
      push_exp("t1_open", 7'h00, 7'h00, 1'b1, 2, 0, 8);
      beat(1'b0, 32'h1111_0003, 2'd0);
      beat(1'b1, 32'h1111_0004, 2'd0);
      beat(1'b1, 32'h2222_0001, 2'd0);
      beat(1'b0, 32'h3333_0001, 2'd0);
      beat(1'b1, 32'h3333_0002, 2'd0);
      push_exp("t1_done", 7'h00, 7'h00, 1'b0, 7, 3, 28);
      idle();

      // Stall of exactly MAX_STALL cycles is legal.
      do_reset();
      repeat (16) step(1'b1, 1'b0, 1'b1, 32'hABCD_0016, 4'hF, 4'hF, 2'd0);
      push_exp("stall16", 7'h00, 7'h00, 1'b0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 32'hABCD_0016, 4'hF, 4'hF, 2'd0);
      push_exp("stall16_beat", 7'h00, 7'h00, 1'b0, 1, 1, 4);
      idle();

      // One stall cycle beyond MAX_STALL.
      do_reset();
      repeat (17) step(1'b1, 1'b0, 1'b1, 32'hABCD_0017, 4'hF, 4'hF, 2'd0);
      push_exp("stall17", 7'h40, 7'h40, 1'b0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 32'hABCD_0017, 4'hF, 4'hF, 2'd0);
      push_exp("stall17_beat", 7'h40, 7'h40, 1'b0, 1, 1, 4);
      idle();

      // Payload changes while stalled.
      do_reset();
      step(1'b1, 1'b0, 1'b1, 32'hAAAA_AAAA, 4'hF, 4'hF, 2'd0);
      step(1'b1, 1'b0, 1'b1, 32'hBBBB_BBBB, 4'hF, 4'hF, 2'd0);
      push_exp("unstable", 7'h02, 7'h02, 1'b0, 0, 0, 0);
      step(1'b1, 1'b0, 1'b1, 32'hBBBB_BBBB, 4'hF, 4'hF, 2'd0);
      push_exp("unstable_hold", 7'h02, 7'h02, 1'b0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 32'hBBBB_BBBB, 4'hF, 4'hF, 2'd0);
      push_exp("unstable_beat", 7'h02, 7'h02, 1'b0, 1, 1, 4);
      idle();

      // Five-beat packet against a four-beat limit.
      do_reset();
      for (int i = 0; i < 4; i++) beat(1'b0, 32'(i), 2'd1);
      push_exp("len4", 7'h00, 7'h00, 1'b1, 4, 0, 16);
      beat(1'b1, 32'h5, 2'd1);
      push_exp("len5", 7'h10, 7'h10, 1'b0, 5, 1, 20);
      idle();

      // TID changes mid-packet: only the no-interleave monitors object.
      do_reset();
      beat(1'b0, 32'hC0DE_0001, 2'd1);
      push_exp("route_b1", 7'h00, 7'h00, 1'b1, 1, 0, 4);
      beat(1'b1, 32'hC0DE_0002, 2'd2);
      push_exp("route_b2", 7'h20, 7'h00, 1'b0, 2, 1, 8);
      idle();

      // Reset in the middle of an open packet discards it.
      do_reset();
      beat(1'b0, 32'hD00D_0001, 2'd0);
      beat(1'b0, 32'hD00D_0002, 2'd0);
      push_exp("open2", 7'h00, 7'h00, 1'b1, 2, 0, 8);
      resetn = 1'b0;
      idle();
      push_exp("mid_reset", 7'h00, 7'h00, 1'b0, 0, 0, 0);
      resetn = 1'b1;
      idle();
      beat(1'b0, 32'hF00D_0001, 2'd3);
      push_exp("fresh1", 7'h00, 7'h00, 1'b1, 1, 0, 4);
      beat(1'b1, 32'hF00D_0002, 2'd3);
      push_exp("fresh2", 7'h00, 7'h00, 1'b0, 2, 1, 8);
      idle();

      // Strobe set on a null byte; byte count follows TKEEP.
      do_reset();
      step(1'b1, 1'b1, 1'b1, 32'h0012_3456, 4'b0111, 4'b1111, 2'd0);
      push_exp("strb_keep", 7'h08, 7'h08, 1'b0, 1, 1, 3);
      idle();

      // TVALID high in the first cycle after reset.
      resetn = 1'b0;
      idle();
      resetn = 1'b1;
      beat(1'b1, 32'h7777_7777, 2'd0);
      push_exp("reset_valid", 7'h04, 7'h04, 1'b0, 1, 1, 4);
      idle();

      // TVALID withdrawn before the handshake.
      do_reset();
      step(1'b1, 1'b0, 1'b0, 32'h9999_9999, 4'hF, 4'hF, 2'd0);
      step(1'b0, 1'b0, 1'b0, 32'h9999_9999, 4'hF, 4'hF, 2'd0);
      push_exp("valid_drop", 7'h01, 7'h01, 1'b0, 0, 0, 0);
      idle();

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
